// File: rtl/pwm_word_serializer_if.sv
// Sample handshake bundle for pwm_word_serializer.
//   data_i  : sample word (WORD_LENGTH bits), driven by the source
//   valid_i : data_i holds a sample, driven by the source
//   ready_o : serializer can take a sample, driven by the serializer
interface pwm_word_serializer_if #(
    parameter int unsigned WORD_LENGTH = 16
);
    logic [WORD_LENGTH-1:0] data_i;
    logic                   valid_i;
    logic                   ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/pwm_word_serializer.sv
// Buffered parallel-to-serial converter for the audio output path.
// Each bit of a WORD_LENGTH-bit sample is held on pwm_audio_o for
// DIV = SYSTEM_FREQUENCY / BIT_RATE clocks; one extra sample can wait in a
// holding buffer so consecutive words stream with no gap.
// Ports:
//   clock_i     : system clock, rising edge
//   reset_i     : synchronous active-high reset
//   in_if       : sample handshake (data_i, valid_i in; ready_o out)
//   pwm_audio_o : registered serial output
//   busy_o      : a word is being shifted
//   done_o      : one-cycle pulse after a word's last bit period
//   underrun_o  : sticky, a word finished with nothing queued behind it
module pwm_word_serializer #(
    parameter int unsigned WORD_LENGTH      = 16,
    parameter int unsigned SYSTEM_FREQUENCY = 100000000,
    parameter int unsigned BIT_RATE         = 1000000,
    parameter bit          MSB_FIRST        = 1'b1,
    parameter bit          IDLE_LEVEL       = 1'b0
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    pwm_word_serializer_if.slave   in_if,
    output logic                   pwm_audio_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   underrun_o
);

    localparam int unsigned DIV   = SYSTEM_FREQUENCY / BIT_RATE;
    localparam int unsigned BIT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_LENGTH-1:0] sreg_q, sreg_d;
    logic [WORD_LENGTH-1:0] hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                   pwm_q, pwm_d;
    logic                   done_q, done_d;
    logic                   underrun_q, underrun_d;

    logic                   accept_c;
    logic                   div_last_c;
    logic                   bit_last_c;
    logic [WORD_LENGTH-1:0] sreg_shift_c;

    // Bit that goes on the line first for a freshly loaded word.
    function automatic logic first_bit(input logic [WORD_LENGTH-1:0] w);
        return MSB_FIRST ? w[WORD_LENGTH-1] : w[0];
    endfunction

    // Advance the shift register by one bit in the configured direction.
    function automatic logic [WORD_LENGTH-1:0] shift_word(input logic [WORD_LENGTH-1:0] w);
        return MSB_FIRST ? {w[WORD_LENGTH-2:0], 1'b0} : {1'b0, w[WORD_LENGTH-1:1]};
    endfunction

    assign in_if.ready_o = !reset_i && !hold_full_q;
    assign accept_c      = in_if.valid_i && in_if.ready_o;
    assign div_last_c    = (div_cnt_q == DIV_W'(DIV - 1));
    assign bit_last_c    = (bit_cnt_q == BIT_W'(WORD_LENGTH - 1));

    assign pwm_audio_o = pwm_q;
    assign busy_o      = (state_q == SHIFT);
    assign done_o      = done_q;
    assign underrun_o  = underrun_q;

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        pwm_d        = pwm_q;
        done_d       = 1'b0;
        underrun_d   = underrun_q;
        sreg_shift_c = shift_word(sreg_q);

        case (state_q)
            IDLE: begin
                pwm_d = IDLE_LEVEL;
                // Empty pipeline: bypass the holding buffer.
                if (accept_c) begin
                    sreg_d    = in_if.data_i;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    pwm_d     = first_bit(in_if.data_i);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!div_last_c) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!bit_last_c) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        sreg_d    = sreg_shift_c;
                        pwm_d     = first_bit(sreg_shift_c);
                    end else begin
                        // Word boundary: chain the next word without a gap if one exists.
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        if (hold_full_q) begin
                            sreg_d      = hold_q;
                            hold_full_d = 1'b0;
                            pwm_d       = first_bit(hold_q);
                        end else if (accept_c) begin
                            sreg_d = in_if.data_i;
                            pwm_d  = first_bit(in_if.data_i);
                        end else begin
                            state_d    = IDLE;
                            pwm_d      = IDLE_LEVEL;
                            underrun_d = 1'b1;
                        end
                    end
                end
                // Words arriving mid-word wait in the holding buffer; a word
                // arriving on the boundary edge was loaded straight into sreg.
                if (accept_c && !(div_last_c && bit_last_c)) begin
                    hold_d      = in_if.data_i;
                    hold_full_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            pwm_q       <= IDLE_LEVEL;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            pwm_q       <= pwm_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pwm_word_serializer.sv
// Scoreboard bench for pwm_word_serializer (WORD_LENGTH=8, DIV=4).
// Stimulus pushes expected words into a queue; monitors rebuild words from
// the serial line and compare independently of the stimulus.
module tb_pwm_word_serializer;

    localparam int unsigned WL  = 8;
    localparam int unsigned DIV = 4;
    localparam int unsigned WORD_CYC = WL * DIV;

    logic clk;
    logic rst;

    pwm_word_serializer_if #(.WORD_LENGTH(WL)) msb_if ();
    pwm_word_serializer_if #(.WORD_LENGTH(WL)) lsb_if ();

    logic msb_pwm, msb_busy, msb_done, msb_underrun;
    logic lsb_pwm, lsb_busy, lsb_done, lsb_underrun;

    pwm_word_serializer #(
        .WORD_LENGTH(WL), .SYSTEM_FREQUENCY(100000000), .BIT_RATE(25000000),
        .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
    ) dut_msb (
        .clock_i(clk), .reset_i(rst), .in_if(msb_if),
        .pwm_audio_o(msb_pwm), .busy_o(msb_busy), .done_o(msb_done), .underrun_o(msb_underrun)
    );

    pwm_word_serializer #(
        .WORD_LENGTH(WL), .SYSTEM_FREQUENCY(100000000), .BIT_RATE(25000000),
        .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
    ) dut_lsb (
        .clock_i(clk), .reset_i(rst), .in_if(lsb_if),
        .pwm_audio_o(lsb_pwm), .busy_o(lsb_busy), .done_o(lsb_done), .underrun_o(lsb_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;
    bit mon_en     = 1'b0;

    logic [WL-1:0] exp_q[$];
    logic          lsb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor for the MSB-first instance: rebuilds each word from the line.
    initial begin : mon_msb
        bit            in_word = 1'b0;
        bit            pending = 1'b0;
        bit            rst_seen = 1'b0;
        int            cyc = 0;
        logic          cur_bit = 1'b0;
        logic [WL-1:0] word = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_seen) begin
                    in_word = 1'b0;
                    cyc     = 0;
                    pending = 1'b0;
                end
                chk("done_o", 32'(msb_done), 32'(pending));
                pending = 1'b0;
                if (msb_busy) begin
                    in_word = 1'b1;
                    if (cyc % DIV == 0) begin
                        cur_bit = msb_pwm;
                        word    = {word[WL-2:0], msb_pwm};
                    end else begin
                        chk("bit_hold", 32'(msb_pwm), 32'(cur_bit));
                    end
                    if (cyc == WORD_CYC - 1) begin
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL word: got %0h expected none at %0t", word, $time);
                        end else begin
                            chk("word", 32'(word), 32'(exp_q.pop_front()));
                        end
                        pending = 1'b1;
                        cyc     = 0;
                    end else begin
                        cyc++;
                    end
                end else begin
                    if (in_word && cyc != 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL word_truncated: got %0d cycles expected %0d", cyc, WORD_CYC);
                    end
                    in_word = 1'b0;
                    cyc     = 0;
                    chk("idle_level", 32'(msb_pwm), 32'(0));
                end
                rst_seen = rst;
            end
        end
    end

    // Monitor for the LSB-first instance: per-cycle expected line levels.
    initial begin : mon_lsb
        forever begin
            @(negedge clk);
            if (mon_en && lsb_busy) begin
                if (lsb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL lsb_extra: got busy expected idle at %0t", $time);
                end else begin
                    chk("lsb_bit", 32'(lsb_pwm), 32'(lsb_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input bit check);
        rst            = 1'b1;
        msb_if.valid_i = 1'b1;
        msb_if.data_i  = 8'h55;
        lsb_if.valid_i = 1'b1;
        lsb_if.data_i  = 8'h55;
        repeat (3) begin
            tick();
            settle();
            if (check) begin
                chk("rst_ready", 32'(msb_if.ready_o), 32'(0));
                chk("rst_pwm", 32'(msb_pwm), 32'(0));
                chk("rst_busy", 32'(msb_busy), 32'(0));
                chk("rst_done", 32'(msb_done), 32'(0));
                chk("rst_underrun", 32'(msb_underrun), 32'(0));
            end
        end
        rst            = 1'b0;
        msb_if.valid_i = 1'b0;
        lsb_if.valid_i = 1'b0;
        settle();
        if (check) chk("post_rst_ready", 32'(msb_if.ready_o), 32'(1));
        tick();
        settle();
        if (check) chk("post_rst_busy", 32'(msb_busy), 32'(0));
    endtask

    initial begin : stim
        int busy_drops;
        int done_seen;
        int busy_seen;
        rst            = 1'b1;
        msb_if.valid_i = 1'b0;
        msb_if.data_i  = '0;
        lsb_if.valid_i = 1'b0;
        lsb_if.data_i  = '0;

        // Reset values
        do_reset(1'b1);
        mon_en = 1'b1;

        // Single word 0xA5
        msb_if.valid_i = 1'b1;
        msb_if.data_i  = 8'hA5;
        exp_q.push_back(8'hA5);
        tick();
        msb_if.valid_i = 1'b0;
        settle();
        chk("single_latency_busy", 32'(msb_busy), 32'(1));
        chk("single_first_bit", 32'(msb_pwm), 32'(1));
        repeat (WORD_CYC) tick();
        settle();
        chk("single_done", 32'(msb_done), 32'(1));
        chk("single_underrun", 32'(msb_underrun), 32'(1));
        chk("single_idle_busy", 32'(msb_busy), 32'(0));
        tick();
        settle();
        chk("single_done_once", 32'(msb_done), 32'(0));

        // Back-to-back 0xFF then 0x00 through the holding buffer
        do_reset(1'b0);
        msb_if.valid_i = 1'b1;
        msb_if.data_i  = 8'hFF;
        exp_q.push_back(8'hFF);
        tick();
        msb_if.data_i  = 8'h00;
        exp_q.push_back(8'h00);
        tick();
        msb_if.valid_i = 1'b0;
        settle();
        chk("b2b_ready_low", 32'(msb_if.ready_o), 32'(0));
        busy_drops = 0;
        for (int i = 2; i <= 2 * WORD_CYC; i++) begin
            if (msb_busy !== 1'b1) busy_drops++;
            if (i == WORD_CYC) chk("b2b_ready_before_boundary", 32'(msb_if.ready_o), 32'(0));
            if (i == WORD_CYC + 1) begin
                chk("b2b_ready_after_boundary", 32'(msb_if.ready_o), 32'(1));
                chk("b2b_no_early_underrun", 32'(msb_underrun), 32'(0));
                chk("b2b_second_first_bit", 32'(msb_pwm), 32'(0));
            end
            tick();
            settle();
        end
        chk("b2b_busy_drops", 32'(busy_drops), 32'(0));
        chk("b2b_underrun", 32'(msb_underrun), 32'(1));
        chk("b2b_end_busy", 32'(msb_busy), 32'(0));

        // Boundary bypass: second word accepted exactly on the boundary edge
        do_reset(1'b0);
        msb_if.valid_i = 1'b1;
        msb_if.data_i  = 8'h3C;
        exp_q.push_back(8'h3C);
        tick();
        msb_if.valid_i = 1'b0;
        busy_drops = 0;
        for (int i = 1; i <= 2 * WORD_CYC; i++) begin
            settle();
            if (msb_busy !== 1'b1) busy_drops++;
            if (i == WORD_CYC) begin
                msb_if.valid_i = 1'b1;
                msb_if.data_i  = 8'hC3;
                exp_q.push_back(8'hC3);
            end
            if (i == WORD_CYC + 1) begin
                chk("bypass_no_underrun", 32'(msb_underrun), 32'(0));
                chk("bypass_first_bit", 32'(msb_pwm), 32'(1));
            end
            tick();
            msb_if.valid_i = 1'b0;
        end
        settle();
        chk("bypass_busy_drops", 32'(busy_drops), 32'(0));
        chk("bypass_underrun", 32'(msb_underrun), 32'(1));

        // LSB-first instance sends 0x01
        do_reset(1'b0);
        for (int i = 0; i < int'(WORD_CYC); i++) lsb_q.push_back(i < int'(DIV));
        lsb_if.valid_i = 1'b1;
        lsb_if.data_i  = 8'h01;
        tick();
        lsb_if.valid_i = 1'b0;
        settle();
        chk("lsb_latency_busy", 32'(lsb_busy), 32'(1));
        repeat (WORD_CYC + 2) tick();
        settle();
        chk("lsb_queue_drained", 32'(lsb_q.size()), 32'(0));
        chk("lsb_underrun", 32'(lsb_underrun), 32'(1));
        chk("lsb_idle", 32'(lsb_pwm), 32'(0));

        // Reset mid-word with the holding buffer full
        do_reset(1'b0);
        msb_if.valid_i = 1'b1;
        msb_if.data_i  = 8'h96;
        tick();
        msb_if.data_i  = 8'h5A;
        tick();
        msb_if.valid_i = 1'b0;
        settle();
        chk("midrst_hold_full", 32'(msb_if.ready_o), 32'(0));
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("midrst_pwm", 32'(msb_pwm), 32'(0));
        chk("midrst_busy", 32'(msb_busy), 32'(0));
        chk("midrst_done", 32'(msb_done), 32'(0));
        chk("midrst_ready", 32'(msb_if.ready_o), 32'(1));
        done_seen = 0;
        busy_seen = 0;
        repeat (2 * WORD_CYC) begin
            tick();
            settle();
            if (msb_done === 1'b1) done_seen++;
            if (msb_busy === 1'b1) busy_seen++;
        end
        chk("midrst_no_done", 32'(done_seen), 32'(0));
        chk("midrst_no_busy", 32'(busy_seen), 32'(0));
        msb_if.valid_i = 1'b1;
        msb_if.data_i  = 8'hC5;
        exp_q.push_back(8'hC5);
        tick();
        msb_if.valid_i = 1'b0;
        repeat (WORD_CYC) tick();
        settle();
        chk("midrst_next_done", 32'(msb_done), 32'(1));
        chk("midrst_next_underrun", 32'(msb_underrun), 32'(1));

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_word_serializer.md
# pwm_word_serializer

Parametrised, buffered parallel-to-serial converter for the audio output path. It accepts `WORD_LENGTH`-bit samples through a valid/ready handshake and holds one sample in a buffer while the previous one is shifted out. Each bit is driven on `pwm_audio_o` for a programmable number of system clocks. Consecutive words stream back-to-back with no gap, and the block replaces the fixed-rate, unbuffered serializer in the audio chain.

## Interface
- `WORD_LENGTH`, 16: bits per sample; must be ≥ 2.
- `SYSTEM_FREQUENCY`, 100000000: clock_i frequency in Hz.
- `BIT_RATE`, 1000000: serial bit rate in Hz. `DIV = SYSTEM_FREQUENCY / BIT_RATE` (integer, ≥ 1) is the number of clocks each bit is held.
- `MSB_FIRST`, 1: 1 shifts bit `WORD_LENGTH-1` first; 0 shifts bit 0 first.
- `IDLE_LEVEL`, 0: level of `pwm_audio_o` when no word is being shifted.

Ports (one clock; reset is synchronous and active-high):
- `clock_i` in 1: system clock, all logic on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `data_i` in WORD_LENGTH: sample to send.
- `valid_i` in 1: `data_i` is valid.
- `ready_o` out 1: block can take a word. Equals `!reset_i && !hold_full`.
- `pwm_audio_o` out 1: registered serial output.
- `busy_o` out 1: high in state SHIFT.
- `done_o` out 1: one-cycle pulse when a word's last bit period completes.
- `underrun_o` out 1: sticky; set when a word completes with no next word available after streaming had begun; cleared only by reset.

## Operation
- Storage: shift register `sreg`, bit counter `bit_cnt` (0..WORD_LENGTH-1), period counter `div_cnt` (0..DIV-1), holding buffer `hold` with flag `hold_full`.
- A word is accepted on any edge where `valid_i && ready_o`.
- **State IDLE**
  - An accepted word loads directly into `sreg`, bypassing `hold`.
  - Both counters clear and the state goes to SHIFT.
  - `pwm_audio_o` shows the first bit from the next cycle.
- **State SHIFT**
  - An accepted word goes to `hold` and sets `hold_full`.
  - `div_cnt` increments each cycle and wraps at DIV-1.
  - On each wrap, `bit_cnt` increments and the next bit is presented.
- **Word boundary edge** (`bit_cnt == WORD_LENGTH-1 && div_cnt == DIV-1`):
  - `done_o` is asserted for the next cycle.
  - If `hold_full`: `hold` moves to `sreg` and `hold_full` clears (ready_o rises the next cycle). The state stays SHIFT and the next word's first bit follows with no gap.
  - Else, if a word is accepted on this same edge: it loads directly into `sreg` and the state stays SHIFT with no gap.
  - Otherwise: the state goes to IDLE, `pwm_audio_o` goes to IDLE_LEVEL, and `underrun_o` is set.
- Bit order follows `MSB_FIRST`. The shift direction is fixed at elaboration.
- **Reset**
  - Takes effect on any cycle, including mid-word.
  - State IDLE, `hold_full` = 0, counters 0.
  - `pwm_audio_o` = IDLE_LEVEL; `busy_o`, `done_o`, `underrun_o` = 0.
  - `ready_o` = 0 while reset_i is high and 1 on the first cycle after.
  - Any word in progress or in `hold` is discarded. No `done_o` is issued for it.

## Timing
- Latency: word accepted at edge E in IDLE → its first bit is on `pwm_audio_o` during cycles E+1 .. E+DIV.
- Each word occupies exactly WORD_LENGTH × DIV cycles.
- `done_o` is high for the single cycle in which the next word's first bit (or IDLE_LEVEL) appears.
- `busy_o` is high from E+1 until the cycle after the final boundary edge.
- Throughput: one word per WORD_LENGTH × DIV cycles, sustained, provided each new word is accepted before the current word's boundary edge.
- DIV = 1 is valid: one bit per clock, and the boundary edge is every WORD_LENGTH cycles.

## Test plan
Bench parameters: WORD_LENGTH=8, SYSTEM_FREQUENCY=100000000, BIT_RATE=25000000 (DIV=4), MSB_FIRST=1.

- **Reset values:** hold reset_i for 3 cycles with valid_i=1 → no accept; `pwm_audio_o`=0, `ready_o`=0 during reset and 1 after, `busy_o`=`done_o`=`underrun_o`=0.
- **Single word:** 0xA5 accepted in IDLE → `pwm_audio_o` = 1,0,1,0,0,1,0,1, each for 4 cycles starting the cycle after accept. `done_o` pulses once 32 cycles after the accept edge, then the output returns to 0 and `underrun_o`=1.
- **Back-to-back:** accept 0xFF, then 0x00 while shifting → `ready_o` low until the boundary. The line shows 32 ones followed immediately by 32 zeros, with two `done_o` pulses 32 cycles apart and `underrun_o` set only after the second.
- **Boundary bypass:** accept a second word exactly on the first word's boundary edge with `hold` empty → no idle gap, and `busy_o` never drops.
- **LSB-first:** rebuild with MSB_FIRST=0 and send 0x01 → a 1 for the first 4 cycles, then 28 cycles of 0.
- **Reset mid-word:** assert reset_i at bit 3 with `hold` full → next cycle `pwm_audio_o`=0, `busy_o`=0, and no `done_o`. The next accepted word transmits normally.
